// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared state type, defaults and width helper for the FIFO read packer
package fifo_pkg;

  // Read-side sequencer states: wait, pop, capture, present packed word
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    CAPT = 2'd2,
    HOLD = 2'd3
  } rd_state_t;

  localparam int FIFO_WIDTH   = 4;
  localparam int FIFO_PACK    = 2;
  localparam int FIFO_TIMEOUT = 16;

  // Width needed to hold a word count of 0..pack
  function automatic int count_width(input int pack);
    return $clog2(pack + 1);
  endfunction

endpackage

// File: rtl/fifo_idle_timer.sv
// rtl/fifo_idle_timer.sv - saturating idle counter that flags expiry at TIMEOUT-1
module fifo_idle_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  if (TIMEOUT > 0) begin : g_timer
    localparam int            TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] count_q;

    // Count enabled cycles, parking on the last value until cleared
    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        count_q <= '0;
      end else if (clr_i) begin
        count_q <= '0;
      end else if (en_i && (count_q != LAST)) begin
        count_q <= count_q + TW'(1);
      end
    end

    assign expired_o = (count_q == LAST);
  end else begin : g_no_timer
    // Timeout disabled: never expires, inputs intentionally unused
    logic unused_inputs;
    assign unused_inputs = ^{clk_i, reset_ni, clr_i, en_i};
    assign expired_o     = 1'b0;
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - pops FIFO words and packs PACK of them into one handshaked output word
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int WIDTH   = FIFO_WIDTH,
  parameter int PACK    = FIFO_PACK,
  parameter int TIMEOUT = FIFO_TIMEOUT,
  parameter int CW      = count_width(PACK)
) (
  input  logic                    rd_clk,
  input  logic                    reset,
  input  logic                    fifo_empty,
  input  logic [WIDTH-1:0]        fifo_data,
  output logic                    fifo_read,
  input  logic                    flush,
  output logic [WIDTH*PACK-1:0]   out_data,
  output logic [CW-1:0]           out_count,
  output logic                    out_valid,
  input  logic                    out_ready
);

  rd_state_t             state_q;
  logic [CW-1:0]         idx_q;
  logic [CW-1:0]         idx_d;
  logic [WIDTH*PACK-1:0] pack_q;
  logic [WIDTH*PACK-1:0] pack_d;
  logic [WIDTH*PACK-1:0] out_data_q;
  logic [CW-1:0]         out_count_q;
  logic                  out_valid_q;
  logic                  timer_en;
  logic                  timer_expired;

  // Packing register with the incoming word dropped into slot idx
  always_comb begin
    idx_d  = idx_q + CW'(1);
    pack_d = pack_q;
    for (int s = 0; s < PACK; s++) begin
      if (idx_q == CW'(s)) begin
        pack_d[s*WIDTH +: WIDTH] = fifo_data;
      end
    end
  end

  // Idle timer only runs while a partial pack waits on an empty FIFO
  assign timer_en = (state_q == IDLE) && (idx_q != '0) && fifo_empty;

  fifo_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk_i     (rd_clk),
    .reset_ni  (reset),
    .clr_i     (!timer_en),
    .en_i      (timer_en),
    .expired_o (timer_expired)
  );

  // Pop is gated by empty so a late empty in READ cancels the request
  assign fifo_read = (state_q == READ) && !fifo_empty;

  // Read sequencer with registered output word, count and valid
  always_ff @(posedge rd_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      pack_q      <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q <= READ;
          end else if ((idx_q != '0) && (flush || timer_expired)) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            out_data_q  <= pack_q;
            out_count_q <= idx_q;
          end
        end
        READ: begin
          state_q <= fifo_empty ? IDLE : CAPT;
        end
        CAPT: begin
          pack_q <= pack_d;
          idx_q  <= idx_d;
          if (idx_d == CW'(PACK)) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            out_data_q  <= pack_d;
            out_count_q <= idx_d;
          end else if (!fifo_empty) begin
            state_q <= READ;
          end else begin
            state_q <= IDLE;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            pack_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side consumer for the 4-bit circular FIFO, running in the `rd_clk` domain. It pops words through the FIFO read port and packs `PACK` consecutive words into one wide output word. The wide word is presented downstream on a valid/ready handshake. Partial packs are emitted on an explicit `flush` or after an empty-FIFO idle timeout, so no data is stranded.

## Interface
- `WIDTH`, 4, FIFO word width in bits.
- `PACK`, 2, FIFO words per output word; must be ≥2.
- `TIMEOUT`, 16, idle `rd_clk` cycles with a partial pack and an empty FIFO before a forced emit; 0 disables the timeout.
- `CW`, `$clog2(PACK+1)`, width of `out_count`.

- `rd_clk` in 1: clock, shared with the FIFO read side.
- `reset` in 1: reset, asynchronous, active-low.
- `fifo_empty` in 1: FIFO empty flag, synchronous to `rd_clk`.
- `fifo_data` in WIDTH: FIFO read data, valid the cycle after `fifo_read`.
- `fifo_read` out 1: one-cycle pop request.
- `flush` in 1: level; emits the partial pack when idle.
- `out_data` out WIDTH*PACK: packed word; first-popped word in bits [WIDTH-1:0].
- `out_count` out CW: number of valid words in `out_data`, 1..PACK.
- `out_valid` out 1: output word available.
- `out_ready` in 1: downstream accept.

## Operation
- State machine with four states: IDLE, READ, CAPT, HOLD. Also holds slot index `idx` (0..PACK) and a packing register.
- **Reset (async, `reset`=0):**
  - state=IDLE, `idx`=0, packing register=0, timer=0.
  - `fifo_read`=0, `out_valid`=0, `out_data`=0, `out_count`=0.
  - A word popped but not yet captured is discarded; this loss is accepted.
- **IDLE:**
  - `fifo_empty`=0 → READ.
  - Else, if `idx`>0 and (`flush`=1 or timer==TIMEOUT-1) → HOLD.
  - Else stay. The timer increments while `idx`>0 and `fifo_empty`=1, and clears otherwise.
- **READ:**
  - `fifo_read` = !`fifo_empty`; this is combinational gating, so a pop is never issued on empty.
  - If `fifo_empty`=1 → IDLE with no capture; otherwise → CAPT.
- **CAPT:**
  - Slot `idx` ← `fifo_data`, then `idx`++.
  - If the new `idx`==PACK → HOLD; else if `fifo_empty`=0 → READ; else → IDLE.
- **HOLD:**
  - `out_valid`=1, `out_count`=`idx`. `out_data` is the packing register, with unused slots zero.
  - `out_data` and `out_count` stay stable until accepted.
  - On `out_valid`&&`out_ready`: clear `idx` and the register, then → IDLE.
- `flush` is ignored outside IDLE. `flush` with `idx`=0 has no effect.
- `fifo_empty` rising in the same cycle as READ cancels the pop. A rise during CAPT does not affect the capture.

## Timing
- Pop-to-capture latency: 1 cycle. `fifo_data` is sampled on the edge ending CAPT.
- Steady-state throughput: 1 word per 2 cycles (READ, CAPT alternate).
- Full pack with `out_ready` held at 1, starting from a non-empty FIFO in IDLE:
  - `out_valid` rises 1+2*PACK cycles after the first IDLE→READ decision.
  - `out_valid` stays high for exactly 1 cycle.
- One bubble cycle (IDLE) follows every accept before the next READ.
- `out_valid` never drops without `out_ready`; there is no combinational path from `out_ready` to `out_valid`.
- All outputs are registered except `fifo_read`, which is decoded from state and gated by `fifo_empty`.

## Structure
- Package `fifo_pkg`:
  - state enum `rd_state_t` (IDLE, READ, CAPT, HOLD).
  - default `WIDTH`/`PACK`/`TIMEOUT` constants.
  - width function for `CW`.
- One sub-module, `fifo_idle_timer`: a saturating counter with clear and enable that outputs `expired` at TIMEOUT-1. It is tied off when TIMEOUT=0.

## Test plan
- Reset: hold `reset`=0 mid-HOLD with `out_data`=8'h21 → within the same cycle `out_valid`=0 and `out_data`=0; after release, state is IDLE and `fifo_read`=0.
- Full pack: FIFO holds 1,2,3,4, `out_ready`=1 → two outputs, 8'h21 then 8'h43, each with `out_count`=2, and exactly 4 `fifo_read` pulses.
- Backpressure: FIFO holds 5,6, `out_ready`=0 for 10 cycles then 1 → `out_data`=8'h65 stable for all 11 cycles, no `fifo_read` during HOLD, single accept.
- Timeout: a single word 7, FIFO then empty, `flush`=0 → `out_valid` rises with `out_data`=8'h07, `out_count`=1, TIMEOUT cycles after the FIFO goes empty.
- Flush: a single word 9, then `flush`=1 in IDLE → `out_data`=8'h09, `out_count`=1 on the next cycle. Then `flush`=1 with `idx`=0 → no `out_valid`.
- Empty race: `fifo_empty` rises in the READ cycle → `fifo_read` stays 0, no capture, state returns to IDLE, and `idx` is unchanged.
